univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- WIDTH, 8, register width in bits (>=2).
- RST_VAL, 0, WIDTH-bit value loaded into o_Q on reset.
REQ-002 Ports (name, direction, width, meaning), one per line; CW = $clog2(WIDTH+1):
- i_clk, in, 1, single clock, rising edge.
- i_rst, in, 1, reset; asynchronous, active-high.
- i_en, in, 1, enable for an immediate single operation.
- i_mode, in, 3, operation select.
- i_D, in, WIDTH, parallel load data.
- i_sin, in, 1, serial input bit.
- i_start, in, 1, burst start request.
- i_num, in, CW, burst operation count.
- o_Q, out, WIDTH, register contents.
- o_sout, out, 1, last bit shifted or rotated out.
- o_busy, out, 1, burst in progress.
- o_done, out, 1, one-cycle burst completion pulse.

Function
REQ-003 i_mode encoding SHALL be:
- 000: hold.
- 001: load, Q<=i_D.
- 010: shift left, LSB<=i_sin, MSB out.
- 011: shift right, MSB<=i_sin, LSB out.
- 100: rotate left.
- 101: rotate right.
- 110: arithmetic shift right, MSB kept, LSB out.
- 111: clear, Q<=0.
REQ-004 Every shift or rotate operation SHALL register the departing bit into o_sout (rotate: the wrapped bit); all other modes SHALL leave o_sout unchanged.
REQ-005 The FSM SHALL have three states, IDLE, RUN and DONE; o_busy=1 only in RUN, and o_done=1 only in DONE.
REQ-006 In IDLE or DONE, with i_start=0 and i_en=1, the block SHALL apply i_mode once at that rising edge, giving 1-cycle latency.
REQ-007 In IDLE or DONE, i_start=1 with i_mode in 010..110 SHALL latch mode and count and take priority over i_en.
- Count nonzero: next state RUN.
- Count zero: next state DONE with o_Q unchanged.
REQ-008 i_start=1 with i_mode in {000,001,111} SHALL be ignored: no op, no o_done, i_en also ignored that cycle.
REQ-009 An i_num value greater than WIDTH SHALL be saturated to WIDTH.
REQ-010 In RUN, one latched-mode operation SHALL occur per rising edge, with i_sin sampled live each cycle.
- Start accepted at edge k with count N: shifts occur at edges k+1..k+N.
- The state is DONE after edge k+N, then IDLE after edge k+N+1.
REQ-011 In RUN, i_en, i_start, i_mode, i_D and i_num SHALL be ignored.
REQ-012 DONE SHALL last exactly one cycle; a new i_start or i_en in DONE SHALL be accepted exactly as in IDLE.
REQ-013 All state SHALL change only on the rising edge of i_clk, except for reset.

Reset
REQ-014 i_rst=1 SHALL, without waiting for a clock edge, force:
- o_Q=RST_VAL, o_sout=0, o_busy=0, o_done=0.
- State IDLE and internal count 0.
REQ-015 Reset asserted during RUN SHALL abort the burst with no o_done pulse.
REQ-016 While i_rst=1, all inputs SHALL be ignored; the first operation SHALL be accepted at the first rising edge after i_rst deasserts.

Verification (WIDTH=8, RST_VAL=0)
REQ-017 Reset: assert i_rst between clock edges with o_Q=8'h5A -> o_Q=8'h00, o_busy=0 and o_done=0 before the next edge.
REQ-018 Immediate ops:
- i_en=1, mode 001, i_D=8'hA5 -> o_Q=8'hA5 after 1 edge.
- Then mode 100 -> o_Q=8'h4B and o_sout=1.
REQ-019 Burst shift right: o_Q=8'h81, mode 011, i_sin=1, i_num=3, i_start pulse ->
- o_busy high for 3 cycles, with o_Q stepping C0, E0, F0.
- Final o_sout=0.
- o_done high for exactly 1 cycle after the third shift.
REQ-020 Arithmetic burst: o_Q=8'h90, mode 110, i_num=8 -> o_Q=8'hFF and o_sout=1 at completion; i_num=15 gives an identical result (saturated to 8).
REQ-021 Corner cases:
- i_start with i_num=0 -> o_done pulse on the next cycle, o_Q unchanged, o_busy never high.
- i_en=1 with mode 111 during RUN -> ignored.
- i_start with mode 001 -> ignored.
REQ-022 Reset mid-burst: i_num=5 shift left, i_rst asserted after 2 shifts -> o_Q=8'h00 and o_busy=0 immediately, with no o_done pulse.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Purpose : universal shift register (load/shift/rotate/arith-shift/clear) with burst FSM.
// Latency : immediate ops land at the next rising edge; an N-op burst spans edges k+1..k+N.
// Backpressure: none; requests during a burst are dropped, o_busy flags that window.
//
// Ports:
//   i_clk, i_rst      rising-edge clock, async active-high reset
//   i_en, i_mode      single immediate operation request and operation select
//   i_D, i_sin        parallel load data, serial input bit (sampled live every op)
//   i_start, i_num    burst request and burst length (saturated to WIDTH)
//   o_Q, o_sout       register contents, last bit shifted/rotated out
//   o_busy, o_done    burst running, one-cycle burst completion pulse
module univ_shift_reg #(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   RST_VAL = '0,
  localparam int                CW      = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [2:0]       i_mode,
  input  logic [WIDTH-1:0] i_D,
  input  logic             i_sin,
  input  logic             i_start,
  input  logic [CW-1:0]    i_num,
  output logic [WIDTH-1:0] o_Q,
  output logic             o_sout,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  localparam logic [CW-1:0] WIDTH_CW = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [2:0]      mode_r;
  logic [CW-1:0]   cnt;

  logic [2:0]       op_mode;
  logic [WIDTH-1:0] op_q;
  logic             op_sout;
  logic             burst_mode;
  logic [CW-1:0]    num_sat;

  // Only the shift/rotate family may be run as a burst; load/hold/clear
  // start requests are dropped entirely.
  assign burst_mode = (i_mode >= M_SHL) && (i_mode <= M_ASR);
  assign num_sat    = (i_num > WIDTH_CW) ? WIDTH_CW : i_num;

  // Next-value datapath, shared by immediate ops and burst steps.
  always_comb begin
    op_mode = (state == RUN) ? mode_r : i_mode;
    op_q    = o_Q;
    op_sout = o_sout;
    case (op_mode)
      M_HOLD: op_q = o_Q;
      M_LOAD: op_q = i_D;
      M_SHL: begin
        op_q    = {o_Q[WIDTH-2:0], i_sin};
        op_sout = o_Q[WIDTH-1];
      end
      M_SHR: begin
        op_q    = {i_sin, o_Q[WIDTH-1:1]};
        op_sout = o_Q[0];
      end
      M_ROL: begin
        op_q    = {o_Q[WIDTH-2:0], o_Q[WIDTH-1]};
        op_sout = o_Q[WIDTH-1];
      end
      M_ROR: begin
        op_q    = {o_Q[0], o_Q[WIDTH-1:1]};
        op_sout = o_Q[0];
      end
      M_ASR: begin
        op_q    = {o_Q[WIDTH-1], o_Q[WIDTH-1:1]};
        op_sout = o_Q[0];
      end
      M_CLR: op_q = '0;
      default: op_q = o_Q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      mode_r <= M_HOLD;
      cnt    <= '0;
      o_Q    <= RST_VAL;
      o_sout <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          o_Q    <= op_q;
          o_sout <= op_sout;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE accept requests identically; DONE always falls
          // back to IDLE unless a new burst is launched.
          state  <= IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b0;
          if (i_start) begin
            if (burst_mode) begin
              mode_r <= i_mode;
              if (num_sat == '0) begin
                state  <= DONE;
                o_done <= 1'b1;
              end else begin
                cnt    <= num_sat;
                state  <= RUN;
                o_busy <= 1'b1;
              end
            end
          end else if (i_en) begin
            o_Q    <= op_q;
            o_sout <= op_sout;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Purpose : directed self-checking bench for univ_shift_reg (WIDTH=8, RST_VAL=0).
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             i_clk;
  logic             i_rst;
  logic             i_en;
  logic [2:0]       i_mode;
  logic [WIDTH-1:0] i_D;
  logic             i_sin;
  logic             i_start;
  logic [CW-1:0]    i_num;
  logic [WIDTH-1:0] o_Q;
  logic             o_sout;
  logic             o_busy;
  logic             o_done;

  int checks = 0;
  int errors = 0;

  univ_shift_reg #(.WIDTH(WIDTH), .RST_VAL(8'h00)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_en),
    .i_mode (i_mode),
    .i_D    (i_D),
    .i_sin  (i_sin),
    .i_start(i_start),
    .i_num  (i_num),
    .o_Q    (o_Q),
    .o_sout (o_sout),
    .o_busy (o_busy),
    .o_done (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [7:0] q, input logic b, input logic d);
    chk({tag, "_q"}, 32'(o_Q), 32'(q));
    chk({tag, "_busy"}, 32'(o_busy), 32'(b));
    chk({tag, "_done"}, 32'(o_done), 32'(d));
  endtask

  task automatic load(input logic [7:0] v);
    i_en = 1'b1; i_mode = 3'b001; i_D = v;
    tick();
    i_en = 1'b0; i_mode = 3'b000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst = 1'b1; i_en = 1'b0; i_mode = 3'b000; i_D = '0;
    i_sin = 1'b0; i_start = 1'b0; i_num = '0;

    // Reset state
    tick(); tick();
    chk_state("rst_init", 8'h00, 1'b0, 1'b0);
    chk("rst_init_sout", 32'(o_sout), 32'd0);
    i_rst = 1'b0;

    // First op accepted on the first edge after reset release
    load(8'h5A);
    chk("load_5a", 32'(o_Q), 32'h5A);

    // Asynchronous reset between edges, then inputs ignored while held
    #2 i_rst = 1'b1;
    #1 chk_state("async_rst", 8'h00, 1'b0, 1'b0);
    i_en = 1'b1; i_mode = 3'b001; i_D = 8'hFF;
    tick();
    chk("rst_ignores_in", 32'(o_Q), 32'h00);
    i_rst = 1'b0; i_en = 1'b0; i_mode = 3'b000;

    // Immediate ops
    load(8'hA5);
    chk("imm_load_a5", 32'(o_Q), 32'hA5);
    i_en = 1'b1; i_mode = 3'b100;
    tick();
    chk("imm_rol_q", 32'(o_Q), 32'h4B);
    chk("imm_rol_sout", 32'(o_sout), 32'd1);
    i_en = 1'b0;

    load(8'h81);
    i_en = 1'b1; i_mode = 3'b101;
    tick();
    chk("imm_ror_q", 32'(o_Q), 32'hC0);
    chk("imm_ror_sout", 32'(o_sout), 32'd1);
    i_mode = 3'b000;
    tick();
    chk("imm_hold_q", 32'(o_Q), 32'hC0);
    chk("imm_hold_sout", 32'(o_sout), 32'd1);
    i_mode = 3'b010; i_sin = 1'b1;
    tick();
    chk("imm_shl_q", 32'(o_Q), 32'h81);
    chk("imm_shl_sout", 32'(o_sout), 32'd1);
    i_mode = 3'b111;
    tick();
    chk("imm_clr_q", 32'(o_Q), 32'h00);
    i_en = 1'b0;

    // Burst shift right x3, with a clear request held during RUN
    load(8'h81);
    i_mode = 3'b011; i_sin = 1'b1; i_num = 4'd3; i_start = 1'b1;
    tick();
    chk_state("shr_accept", 8'h81, 1'b1, 1'b0);
    i_start = 1'b0; i_en = 1'b1; i_mode = 3'b111; i_num = 4'd0;
    tick();
    chk_state("shr_1", 8'hC0, 1'b1, 1'b0);
    tick();
    chk_state("shr_2", 8'hE0, 1'b1, 1'b0);
    tick();
    chk_state("shr_3", 8'hF0, 1'b0, 1'b1);
    chk("shr_sout", 32'(o_sout), 32'd0);
    i_en = 1'b0; i_mode = 3'b000;
    tick();
    chk_state("shr_idle", 8'hF0, 1'b0, 1'b0);

    // Arithmetic burst, exact and saturated counts
    for (int pass = 0; pass < 2; pass++) begin
      load(8'h90);
      i_mode = 3'b110; i_num = (pass == 0) ? 4'd8 : 4'd15; i_start = 1'b1;
      tick();
      i_start = 1'b0; i_mode = 3'b000;
      repeat (7) tick();
      chk_state((pass == 0) ? "asr8_7" : "asr15_7", 8'hFF, 1'b1, 1'b0);
      tick();
      chk_state((pass == 0) ? "asr8_end" : "asr15_end", 8'hFF, 1'b0, 1'b1);
      chk((pass == 0) ? "asr8_sout" : "asr15_sout", 32'(o_sout), 32'd1);
      tick();
      chk_state((pass == 0) ? "asr8_idle" : "asr15_idle", 8'hFF, 1'b0, 1'b0);
    end

    // Zero-count burst: done next cycle, no busy, Q unchanged
    i_mode = 3'b010; i_num = 4'd0; i_start = 1'b1;
    tick();
    chk_state("num0_done", 8'hFF, 1'b0, 1'b1);
    i_start = 1'b0; i_mode = 3'b000;
    tick();
    chk_state("num0_idle", 8'hFF, 1'b0, 1'b0);

    // Start with load mode is ignored, including the concurrent enable
    i_start = 1'b1; i_en = 1'b1; i_mode = 3'b001; i_D = 8'h00; i_num = 4'd3;
    tick();
    chk_state("start_load_ign", 8'hFF, 1'b0, 1'b0);
    i_start = 1'b0; i_en = 1'b0; i_mode = 3'b000;

    // Reset in the middle of a 5-step shift-left burst
    load(8'h01);
    i_mode = 3'b010; i_sin = 1'b0; i_num = 4'd5; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_mode = 3'b000;
    tick(); tick();
    chk_state("mid_2shifts", 8'h04, 1'b1, 1'b0);
    #2 i_rst = 1'b1;
    #1 chk_state("mid_rst", 8'h00, 1'b0, 1'b0);
    i_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_state("mid_after", 8'h00, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
